// File: rtl/codif_morse.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : codif_morse                                               |
// | Description : Registers the Morse pattern of a digit/letter code and    |
// |               splits it into per-position dot and dash indicators.      |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+

module codif_morse_demux (
    input  logic i_disp,
    input  logic i_sym,
    output logic o_ponto,
    output logic o_traco
);
    assign o_ponto = i_disp & ~i_sym;
    assign o_traco = i_disp &  i_sym;
endmodule

module codif_morse (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic [5:0] num,
    output logic [4:0] morse,
    output logic [4:0] display,
    output logic [4:0] ponto,
    output logic [4:0] traco
);
    // Left-aligned symbol-valid masks by symbol count
    localparam logic [4:0] c_len0 = 5'b00000;
    localparam logic [4:0] c_len1 = 5'b10000;
    localparam logic [4:0] c_len2 = 5'b11000;
    localparam logic [4:0] c_len3 = 5'b11100;
    localparam logic [4:0] c_len4 = 5'b11110;
    localparam logic [4:0] c_len5 = 5'b11111;

    logic [4:0] w_morse;
    logic [4:0] w_display;
    logic [4:0] r_morse;
    logic [4:0] r_display;

    // Symbol bits: 1 = dash, first symbol in bit 4, unused bits zero
    always_comb begin
        w_morse   = 5'b00000;
        w_display = c_len0;
        case (num)
            6'd0:  begin w_morse = 5'b11111; w_display = c_len5; end
            6'd1:  begin w_morse = 5'b01111; w_display = c_len5; end
            6'd2:  begin w_morse = 5'b00111; w_display = c_len5; end
            6'd3:  begin w_morse = 5'b00011; w_display = c_len5; end
            6'd4:  begin w_morse = 5'b00001; w_display = c_len5; end
            6'd5:  begin w_morse = 5'b00000; w_display = c_len5; end
            6'd6:  begin w_morse = 5'b10000; w_display = c_len5; end
            6'd7:  begin w_morse = 5'b11000; w_display = c_len5; end
            6'd8:  begin w_morse = 5'b11100; w_display = c_len5; end
            6'd9:  begin w_morse = 5'b11110; w_display = c_len5; end
            6'd10: begin w_morse = 5'b01000; w_display = c_len2; end
            6'd11: begin w_morse = 5'b10000; w_display = c_len4; end
            6'd12: begin w_morse = 5'b10100; w_display = c_len4; end
            6'd13: begin w_morse = 5'b10000; w_display = c_len3; end
            6'd14: begin w_morse = 5'b00000; w_display = c_len1; end
            6'd15: begin w_morse = 5'b00100; w_display = c_len4; end
            6'd16: begin w_morse = 5'b11000; w_display = c_len3; end
            6'd17: begin w_morse = 5'b00000; w_display = c_len4; end
            6'd18: begin w_morse = 5'b00000; w_display = c_len2; end
            6'd19: begin w_morse = 5'b01110; w_display = c_len4; end
            6'd20: begin w_morse = 5'b10100; w_display = c_len3; end
            6'd21: begin w_morse = 5'b01000; w_display = c_len4; end
            6'd22: begin w_morse = 5'b11000; w_display = c_len2; end
            6'd23: begin w_morse = 5'b10000; w_display = c_len2; end
            6'd24: begin w_morse = 5'b11100; w_display = c_len3; end
            6'd25: begin w_morse = 5'b01100; w_display = c_len4; end
            6'd26: begin w_morse = 5'b11010; w_display = c_len4; end
            6'd27: begin w_morse = 5'b01000; w_display = c_len3; end
            6'd28: begin w_morse = 5'b00000; w_display = c_len3; end
            6'd29: begin w_morse = 5'b10000; w_display = c_len1; end
            6'd30: begin w_morse = 5'b00100; w_display = c_len3; end
            6'd31: begin w_morse = 5'b00010; w_display = c_len4; end
            6'd32: begin w_morse = 5'b01100; w_display = c_len3; end
            6'd33: begin w_morse = 5'b10010; w_display = c_len4; end
            6'd34: begin w_morse = 5'b10110; w_display = c_len4; end
            6'd35: begin w_morse = 5'b11000; w_display = c_len4; end
            default: begin w_morse = 5'b00000; w_display = c_len0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_morse   <= 5'b00000;
            r_display <= 5'b00000;
        end else if (ready) begin
            r_morse   <= w_morse;
            r_display <= w_display;
        end
    end

    assign morse   = r_morse;
    assign display = r_display;

    generate
        for (genvar i = 0; i < 5; i++) begin : g_demux
            codif_morse_demux u_demux (
                .i_disp  (r_display[i]),
                .i_sym   (r_morse[i]),
                .o_ponto (ponto[i]),
                .o_traco (traco[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_codif_morse.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_codif_morse                                            |
// | Description : Directed and random checks of codif_morse against a       |
// |               model built from the dot/dash code strings.               |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+

module tb_codif_morse;
    logic       clk;
    logic       reset;
    logic       ready;
    logic [5:0] num;
    logic [4:0] morse;
    logic [4:0] display;
    logic [4:0] ponto;
    logic [4:0] traco;

    int n_checks;
    int n_err;

    logic [4:0] exp_m;
    logic [4:0] exp_d;

    string codes [36];

    codif_morse u_dut (
        .clk     (clk),
        .reset   (reset),
        .ready   (ready),
        .num     (num),
        .morse   (morse),
        .display (display),
        .ponto   (ponto),
        .traco   (traco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: translate the code string symbol by symbol
    task automatic lookup(input logic [5:0] n, output logic [4:0] m, output logic [4:0] d);
        string s;
        m = 5'b00000;
        d = 5'b00000;
        if (n < 36) begin
            s = codes[n];
            for (int k = 0; k < s.len(); k++) begin
                d[4-k] = 1'b1;
                m[4-k] = (s[k] == "-");
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".morse"},   morse,   exp_m);
        chk({tag, ".display"}, display, exp_d);
        chk({tag, ".ponto"},   ponto,   exp_d & ~exp_m);
        chk({tag, ".traco"},   traco,   exp_d & exp_m);
        chk({tag, ".excl"},    ponto & traco, 5'b00000);
    endtask

    task automatic step(input logic r, input logic rd, input logic [5:0] n);
        logic [4:0] m;
        logic [4:0] d;
        @(negedge clk);
        reset = r;
        ready = rd;
        num   = n;
        @(posedge clk);
        #1;
        if (r) begin
            exp_m = 5'b00000;
            exp_d = 5'b00000;
        end else if (rd) begin
            lookup(n, m, d);
            exp_m = m;
            exp_d = d;
        end
    endtask

    initial begin
        codes = '{"-----", ".----", "..---", "...--", "....-",
                  ".....", "-....", "--...", "---..", "----.",
                  ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                  ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                  "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
        n_checks = 0;
        n_err    = 0;
        exp_m    = 5'b00000;
        exp_d    = 5'b00000;
        reset    = 1'b1;
        ready    = 1'b0;
        num      = 6'd0;

        step(1'b1, 1'b0, 6'd0);
        check_all("reset");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 6'(i + 7));
            check_all("idle_after_reset");
        end

        step(1'b0, 1'b1, 6'd1);
        chk("num1.display", display, 5'b11111);
        chk("num1.morse",   morse,   5'b01111);
        chk("num1.ponto",   ponto,   5'b10000);
        chk("num1.traco",   traco,   5'b01111);

        step(1'b0, 1'b1, 6'd10);
        chk("A.display", display, 5'b11000);
        chk("A.morse",   morse,   5'b01000);
        chk("A.ponto",   ponto,   5'b10000);
        chk("A.traco",   traco,   5'b01000);
        step(1'b0, 1'b1, 6'd29);
        chk("T.display", display, 5'b10000);
        chk("T.ponto",   ponto,   5'b00000);
        chk("T.traco",   traco,   5'b10000);

        // Sweep with isolated ready pulses, then back-to-back loads
        for (int n = 0; n < 36; n++) begin
            step(1'b0, 1'b1, 6'(n));
            check_all("sweep_pulse");
            chk("sweep.d0_letter", display[0] ? 5'd1 : 5'd0, (n < 10) ? 5'd1 : 5'd0);
            step(1'b0, 1'b0, 6'(35 - n));
            check_all("sweep_hold");
        end
        for (int n = 35; n >= 0; n--) begin
            step(1'b0, 1'b1, 6'(n));
            check_all("sweep_b2b");
        end

        step(1'b0, 1'b1, 6'd5);
        step(1'b0, 1'b0, 6'd22);
        chk("hold5.display", display, 5'b11111);
        chk("hold5.ponto",   ponto,   5'b11111);
        chk("hold5.traco",   traco,   5'b00000);
        check_all("hold5");

        step(1'b1, 1'b1, 6'd0);
        chk("rst_prio.morse",   morse,   5'b00000);
        chk("rst_prio.display", display, 5'b00000);
        chk("rst_prio.ponto",   ponto,   5'b00000);
        chk("rst_prio.traco",   traco,   5'b00000);
        step(1'b0, 1'b1, 6'd40);
        chk("inv40.display", display, 5'b00000);
        chk("inv40.morse",   morse,   5'b00000);
        step(1'b0, 1'b1, 6'd7);
        step(1'b0, 1'b1, 6'd63);
        check_all("inv63_after_load");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)));
            check_all("random");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/codif_morse.md
CODIF_MORSE -- requirements
Module: codif_morse

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 ready  input  1  load strobe; num is sampled on a rising clk edge while ready=1.
REQ-005 num  input  6  character code: 0-9 are digits '0'-'9'; 10-35 are letters 'A'-'Z'; 36-63 are invalid.
REQ-006 morse  output  5  symbol values, first symbol in bit 4; 1=dash, 0=dot; unused bits are 0.
REQ-007 display  output  5  symbol-valid mask, left-aligned: bits 4 down to 5-len are 1, the rest are 0.
REQ-008 ponto  output  5  per-position dot indicator.
REQ-009 traco  output  5  per-position dash indicator.

Function
REQ-010 morse and display SHALL be registers loaded on a clk edge when ready=1 and reset=0; latency is 1 cycle.
REQ-011 When ready=0 and reset=0, morse and display SHALL hold their values.
REQ-012 For each bit i, ponto[i] SHALL be combinational: display[i] & ~morse[i].
REQ-013 For each bit i, traco[i] SHALL be combinational: display[i] & morse[i].
REQ-014 Implement REQ-012 and REQ-013 as five identical per-position display-demux instances.
REQ-015 ponto[i] and traco[i] SHALL never both be 1.
REQ-016 Code table for digits (symbols in order, first symbol at bit 4):
- 0 -----, 1 .----, 2 ..---, 3 ...--, 4 ....-
- 5 ....., 6 -...., 7 --..., 8 ---.., 9 ----.
REQ-017 Code table for letters:
- A .-, B -..., C -.-., D -.., E ., F ..-., G --., H ...., I ..
- J .---, K -.-, L .-.., M --, N -., O ---, P .--., Q --.-, R .-.
- S ..., T -, U ..-, V ...-, W .--, X -..-, Y -.--, Z --..
REQ-018 Symbol count: digits use 5 symbols; letters use 1-4 symbols, so display[0]=0 for every letter.
REQ-019 Loading any invalid num (36-63) with ready=1 SHALL set morse=00000 and display=00000, giving blank outputs.
REQ-020 All morse bits outside the display mask SHALL be 0.
REQ-021 ready held high for consecutive cycles SHALL reload on every edge, following num each cycle.

Reset
REQ-022 On a clk edge with reset=1, morse and display SHALL become 00000, and therefore ponto=traco=00000.
REQ-023 reset SHALL take priority over ready on the same edge.
REQ-024 After reset, outputs SHALL stay blank until the first load.
REQ-025 reset asserted mid-sequence SHALL discard the displayed character; no partial state remains.

Verification
REQ-026 Load num=1, ready=1, one edge -> display=11111, morse=01111, ponto=10000, traco=01111.
REQ-027 Load num=10 ('A') -> display=11000, morse=01000, ponto=10000, traco=01000; then num=29 ('T') -> display=10000, ponto=00000, traco=10000.
REQ-028 Sweep num=0..35 with ready pulses -> every output matches REQ-016/REQ-017, and ponto&traco=00000 always.
REQ-029 Load num=5, then drop ready and change num=22 -> outputs hold display=11111, ponto=11111, traco=00000.
REQ-030 reset=1 together with ready=1, num=0 -> morse=display=ponto=traco=00000; load num=40 -> all outputs remain 00000.
